// File: rtl/step_pulse_gen.sv
// Debounced up/down step pulse generator with hold-to-auto-repeat for an up/down counter.
// First pulse DB_CYCLES+3 edges after a clean press, then after REP_DELAY, then every REP_RATE.
module step_pulse_gen #(
    parameter logic [19:0] DB_CYCLES = 20'd500000,
    parameter logic [23:0] REP_DELAY = 24'd5000000,
    parameter logic [23:0] REP_RATE  = 24'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_dn,
    output logic inc_p,
    output logic UHDL,
    output logic held
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HOLD_UP = 3'd1;
    localparam logic [2:0] REP_UP  = 3'd2;
    localparam logic [2:0] HOLD_DN = 3'd3;
    localparam logic [2:0] REP_DN  = 3'd4;

    logic [1:0]  up_sync;
    logic [1:0]  dn_sync;
    logic [1:0]  sync_lvl;     // [0] = up, [1] = down
    logic [19:0] db_cnt [2];
    logic [1:0]  db_state;
    logic [1:0]  db_prev;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [23:0] timer;
    logic [23:0] timer_nxt;
    logic [23:0] limit;
    logic        tick;
    logic        pulse;
    logic        pulse_dir;
    logic        up_db;
    logic        dn_db;
    logic        up_rise;
    logic        dn_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_sync <= 2'b00;
            dn_sync <= 2'b00;
        end else begin
            up_sync <= {up_sync[0], btn_up};
            dn_sync <= {dn_sync[0], btn_dn};
        end
    end

    assign sync_lvl = {dn_sync[1], up_sync[1]};

    // Counter runs only while the synchronized level disagrees with the stable state,
    // so any bounce back to the stable level restarts the qualification window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
            db_state  <= 2'b00;
            db_prev   <= 2'b00;
        end else begin
            db_prev <= db_state;
            for (int i = 0; i < 2; i++) begin
                if (sync_lvl[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_CYCLES - 20'd1) begin
                    db_state[i] <= sync_lvl[i];
                    db_cnt[i]   <= '0;
                end else if (db_cnt[i] != '1) begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    assign up_db   = db_state[0];
    assign dn_db   = db_state[1];
    assign up_rise = db_state[0] & ~db_prev[0];
    assign dn_rise = db_state[1] & ~db_prev[1];

    assign limit = (state == HOLD_UP || state == HOLD_DN) ? REP_DELAY : REP_RATE;
    assign tick  = (timer == limit - 24'd1);

    // Release or an opposing press wins over a step that falls due on the same cycle.
    always_comb begin
        state_nxt = state;
        timer_nxt = (timer == '1) ? timer : timer + 24'd1;
        pulse     = 1'b0;
        pulse_dir = UHDL;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (up_rise && !dn_db) begin
                    state_nxt = HOLD_UP;
                    pulse     = 1'b1;
                    pulse_dir = 1'b1;
                end else if (dn_rise && !up_db) begin
                    state_nxt = HOLD_DN;
                    pulse     = 1'b1;
                    pulse_dir = 1'b0;
                end
            end
            HOLD_UP, REP_UP: begin
                if (!up_db || dn_db) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (tick) begin
                    state_nxt = REP_UP;
                    timer_nxt = '0;
                    pulse     = 1'b1;
                    pulse_dir = 1'b1;
                end
            end
            HOLD_DN, REP_DN: begin
                if (!dn_db || up_db) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (tick) begin
                    state_nxt = REP_DN;
                    timer_nxt = '0;
                    pulse     = 1'b1;
                    pulse_dir = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            inc_p <= 1'b0;
            UHDL  <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            inc_p <= pulse;
            held  <= (state_nxt != IDLE);
            if (pulse) begin
                UHDL <= pulse_dir;
            end
        end
    end

endmodule
